// File: rtl/packet_fifo_if.sv
// Handshake and status bundle between a packet producer/consumer and packet_fifo.
interface packet_fifo_if #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8
);
   localparam int PW = $clog2(DEPTH) + 1;

   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_en;
   logic                  wr_last;
   logic                  wr_drop;
   logic                  rd_en;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_last;
   logic                  rd_valid;
   logic                  full;
   logic                  almost_full;
   logic                  empty;
   logic                  almost_empty;
   logic [PW-1:0]         level;
   logic [PW-1:0]         pkt_count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_data, wr_en, wr_last, wr_drop, rd_en, clr_err,
      input  rd_data, rd_last, rd_valid, full, almost_full, empty, almost_empty,
             level, pkt_count, overflow, underflow
   );

   modport slave (
      input  wr_data, wr_en, wr_last, wr_drop, rd_en, clr_err,
      output rd_data, rd_last, rd_valid, full, almost_full, empty, almost_empty,
             level, pkt_count, overflow, underflow
   );
endinterface

// File: rtl/packet_fifo.sv
// Packet FIFO with speculative write pointer: words of an open packet are held
// behind the commit pointer and only become readable once the last word lands.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ACCEPT  | writes are stored; a last word commits the open packet
// ST_DISCARD | packet overflowed; words ignored until its last word arrives
module packet_fifo #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input logic          clk,
   input logic          rst,
   packet_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   localparam logic [0:0] ST_ACCEPT  = 1'b0;
   localparam logic [0:0] ST_DISCARD = 1'b1;

   logic [DATA_WIDTH:0] r_mem [DEPTH];
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_cm_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [PW-1:0]       r_pkt_count;
   logic [0:0]          r_state;
   logic                r_overflow;
   logic                r_underflow;

   logic [PW-1:0]       w_used;
   logic [PW-1:0]       w_level;
   logic                w_full;
   logic                w_empty;
   logic                w_wr_req;
   logic                w_wr_ok;
   logic                w_wr_ovf;
   logic                w_commit;
   logic                w_rd_ok;
   logic                w_rd_unf;
   logic                w_pop_last;
   logic [DATA_WIDTH:0] w_head;

   // Occupancy: used counts the open packet too, level only committed words.
   assign w_used   = r_wr_ptr - r_rd_ptr;
   assign w_level  = r_cm_ptr - r_rd_ptr;
   assign w_full   = (w_used == PW'(DEPTH));
   assign w_empty  = (w_level == '0);

   // A drop in the same cycle swallows the write entirely.
   assign w_wr_req   = bus.wr_en && !bus.wr_drop && (r_state == ST_ACCEPT);
   assign w_wr_ok    = w_wr_req && !w_full;
   assign w_wr_ovf   = w_wr_req && w_full;
   assign w_commit   = w_wr_ok && bus.wr_last;
   assign w_rd_ok    = bus.rd_en && !w_empty;
   assign w_rd_unf   = bus.rd_en && w_empty;
   assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
   assign w_pop_last = w_rd_ok && w_head[DATA_WIDTH];

   // Storage array; contents are not reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {bus.wr_last, bus.wr_data};
      end
   end

   // Write FSM with speculative/commit pointers, plus the read pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_cm_ptr <= '0;
         r_rd_ptr <= '0;
         r_state  <= ST_ACCEPT;
      end else begin
         if (bus.wr_drop) begin
            r_wr_ptr <= r_cm_ptr;
            r_state  <= ST_ACCEPT;
         end else if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (bus.wr_last) begin
               r_cm_ptr <= r_wr_ptr + 1'b1;
            end
         end else if (w_wr_ovf) begin
            r_wr_ptr <= r_cm_ptr;
            if (!bus.wr_last) begin
               r_state <= ST_DISCARD;
            end
         end else if ((r_state == ST_DISCARD) && bus.wr_en && bus.wr_last) begin
            r_state <= ST_ACCEPT;
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Complete-packet counter: commit and pop of a last word cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pkt_count <= '0;
      end else begin
         case ({w_commit, w_pop_last})
            2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
            2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
            default: r_pkt_count <= r_pkt_count;
         endcase
      end
   end

   // Sticky error flags; a new error outranks a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_ovf) begin
            r_overflow <= 1'b1;
         end else if (bus.clr_err) begin
            r_overflow <= 1'b0;
         end
         if (w_rd_unf) begin
            r_underflow <= 1'b1;
         end else if (bus.clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign bus.rd_data      = w_head[DATA_WIDTH-1:0];
   assign bus.rd_last      = w_head[DATA_WIDTH];
   assign bus.rd_valid     = !w_empty;
   assign bus.full         = w_full;
   assign bus.empty        = w_empty;
   assign bus.almost_full  = (w_used >= PW'(AF_LEVEL));
   assign bus.almost_empty = (w_level <= PW'(AE_LEVEL));
   assign bus.level        = w_level;
   assign bus.pkt_count    = r_pkt_count;
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_packet_fifo.sv
// Bench for packet_fifo: queue-based packet model plus read-side scoreboard.
module tb_packet_fifo;
   localparam int DEPTH = 8;
   localparam int DW    = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic clk;
   logic rst;

   packet_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

   packet_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // model: committed words, words of the open packet, discard mode, sticky flags
   logic [8:0] m_cm[$];
   logic [8:0] m_pend[$];
   logic [8:0] sb[$];
   bit         m_disc;
   bit         m_ovf;
   bit         m_unf;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int model_pkts();
      int n = 0;
      foreach (m_cm[i]) if (m_cm[i][8]) n++;
      return n;
   endfunction

   task automatic check_status();
      int lvl;
      int used;
      lvl  = m_cm.size();
      used = lvl + m_pend.size();
      chk("empty",        int'(bus.empty),        int'(lvl == 0));
      chk("rd_valid",     int'(bus.rd_valid),     int'(lvl != 0));
      chk("full",         int'(bus.full),         int'(used == DEPTH));
      chk("almost_full",  int'(bus.almost_full),  int'(used >= AF));
      chk("almost_empty", int'(bus.almost_empty), int'(lvl <= AE));
      chk("level",        int'(bus.level),        lvl);
      chk("pkt_count",    int'(bus.pkt_count),    model_pkts());
      chk("overflow",     int'(bus.overflow),     int'(m_ovf));
      chk("underflow",    int'(bus.underflow),    int'(m_unf));
   endtask

   // One cycle: check state left by the previous edge, then drive and model this one.
   task automatic step(input bit we, input logic [7:0] d, input bit wl,
                       input bit wd, input bit re, input bit ce);
      bit full_m;
      bit ovf_set;
      bit unf_set;
      @(posedge clk);
      #2;
      check_status();
      bus.wr_en   = we;
      bus.wr_data = d;
      bus.wr_last = wl;
      bus.wr_drop = wd;
      bus.rd_en   = re;
      bus.clr_err = ce;

      full_m  = (m_cm.size() + m_pend.size()) == DEPTH;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (re) begin
         if (m_cm.size() != 0) void'(m_cm.pop_front());
         else unf_set = 1'b1;
      end
      if (wd) begin
         m_pend.delete();
         m_disc = 1'b0;
      end else if (we) begin
         if (m_disc) begin
            if (wl) m_disc = 1'b0;
         end else if (full_m) begin
            ovf_set = 1'b1;
            m_pend.delete();
            if (!wl) m_disc = 1'b1;
         end else begin
            m_pend.push_back({wl, d});
            if (wl) begin
               foreach (m_pend[i]) begin
                  m_cm.push_back(m_pend[i]);
                  sb.push_back(m_pend[i]);
               end
               m_pend.delete();
            end
         end
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (ce) m_ovf = 1'b0;
      if (unf_set) m_unf = 1'b1;
      else if (ce) m_unf = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [7:0] d, input bit wl);
      step(1'b1, d, wl, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_empty"},        int'(bus.empty),        1);
      chk({tag, "_almost_empty"}, int'(bus.almost_empty), 1);
      chk({tag, "_full"},         int'(bus.full),         0);
      chk({tag, "_almost_full"},  int'(bus.almost_full),  0);
      chk({tag, "_rd_valid"},     int'(bus.rd_valid),     0);
      chk({tag, "_level"},        int'(bus.level),        0);
      chk({tag, "_pkt_count"},    int'(bus.pkt_count),    0);
      chk({tag, "_overflow"},     int'(bus.overflow),     0);
      chk({tag, "_underflow"},    int'(bus.underflow),    0);
   endtask

   task automatic set_idle_inputs();
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      bus.wr_last = 1'b0;
      bus.wr_drop = 1'b0;
      bus.rd_en   = 1'b0;
      bus.clr_err = 1'b0;
   endtask

   // Async reset asserted between edges; outputs must settle before the next edge.
   task automatic reset_mid();
      @(posedge clk);
      #2;
      set_idle_inputs();
      #2;
      rst = 1'b1;
      #1;
      check_reset_vals("async_rst");
      m_cm.delete();
      m_pend.delete();
      sb.delete();
      m_disc = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      #2;
      rst = 1'b0;
   endtask

   // Monitor: every accepted pop is checked against the oldest scoreboard entry.
   always @(negedge clk) begin
      logic [8:0] exp_w;
      if (!rst && bus.rd_en && bus.rd_valid) begin
         if (sb.size() == 0) begin
            chk("rd_unexpected", 1, 0);
         end else begin
            exp_w = sb.pop_front();
            chk("rd_data", int'(bus.rd_data), int'(exp_w[7:0]));
            chk("rd_last", int'(bus.rd_last), int'(exp_w[8]));
         end
      end
   end

   initial begin
      int guard;
      set_idle_inputs();
      m_disc = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      rst    = 1'b1;
      #3;
      check_reset_vals("reset");
      #5;
      rst = 1'b0;

      // three-word packet, commit then read back
      wr(8'h11, 1'b0);
      wr(8'h22, 1'b0);
      wr(8'h33, 1'b1);
      idle();
      rd(); rd(); rd();
      idle();

      // dropped packet never appears, next packet reads alone
      wr(8'hA0, 1'b0);
      wr(8'hA1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(); idle();
      wr(8'h55, 1'b1);
      idle();
      rd();
      idle();

      // oversize packet: overflow, discard until last, then a clean packet
      for (int i = 0; i < 9; i++) wr(8'(8'h60 + i), 1'b0);
      wr(8'hE1, 1'b0);
      wr(8'hE2, 1'b0);
      wr(8'hE3, 1'b1);
      wr(8'h77, 1'b1);
      idle();
      rd();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();

      // underflow and clear-versus-set priority
      rd();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();

      // committed-full FIFO with simultaneous write and read
      for (int i = 0; i < DEPTH; i++) wr(8'(8'hC0 + i), 1'b1);
      step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0);
      idle();
      for (int i = 0; i < DEPTH - 1; i++) rd();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();

      // async reset mid-packet with committed data present
      wr(8'h91, 1'b1);
      wr(8'h92, 1'b0);
      wr(8'h93, 1'b0);
      reset_mid();
      idle();
      wr(8'h44, 1'b1);
      idle();
      rd();
      idle();

      // random traffic: write-heavy phase then read-heavy phase
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 99) < 60),
                 8'($urandom),
                 bit'($urandom_range(0, 99) < 30),
                 bit'($urandom_range(0, 99) < 4),
                 bit'($urandom_range(0, 99) < (ph == 0 ? 25 : 70)),
                 bit'($urandom_range(0, 99) < 5));
         end
      end

      guard = 0;
      while (m_cm.size() != 0 && guard < 4 * DEPTH) begin
         rd();
         guard++;
      end
      idle();
      idle();
      chk("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
